// File: rtl/vga_fb_arbiter_if.sv
// Pin bundle between the frame-buffer arbiter and its neighbours: VGA timing, drawing engine, SRAM.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface vga_fb_arbiter_if #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 16
);
    logic              i_pix_en;
    logic [10:0]       i_vga_x;
    logic [10:0]       i_vga_y;
    logic              i_vga_active;
    logic              i_vsync_n;
    logic [DATA_W-1:0] o_pixel;

    logic              i_wr_valid;
    logic              o_wr_ready;
    logic [10:0]       i_wr_x;
    logic [10:0]       i_wr_y;
    logic [DATA_W-1:0] i_wr_data;

    logic              i_swap_req;
    logic              o_swap_done;
    logic              o_disp_bank;

    logic [ADDR_W-1:0] o_sram_addr;
    logic [DATA_W-1:0] o_sram_wdata;
    logic              o_sram_we_n;
    logic              o_sram_oe_n;
    logic [DATA_W-1:0] i_sram_rdata;

    modport slave (
        input  i_pix_en, i_vga_x, i_vga_y, i_vga_active, i_vsync_n,
        input  i_wr_valid, i_wr_x, i_wr_y, i_wr_data, i_swap_req, i_sram_rdata,
        output o_pixel, o_wr_ready, o_swap_done, o_disp_bank,
        output o_sram_addr, o_sram_wdata, o_sram_we_n, o_sram_oe_n
    );

    modport master (
        output i_pix_en, i_vga_x, i_vga_y, i_vga_active, i_vsync_n,
        output i_wr_valid, i_wr_x, i_wr_y, i_wr_data, i_swap_req, i_sram_rdata,
        input  o_pixel, o_wr_ready, o_swap_done, o_disp_bank,
        input  o_sram_addr, o_sram_wdata, o_sram_we_n, o_sram_oe_n
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port SRAM frame-buffer arbiter: display reads win pixel slots, queued draw writes fill
// the rest, and the displayed bank flips only on a vsync falling edge with no writes outstanding.
module vga_fb_arbiter #(
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned H_ACT      = 640,
    parameter int unsigned V_ACT      = 480,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic              i_clk,
    input logic              i_reset,
    vga_fb_arbiter_if.slave  bus
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LinW = ADDR_W - 1;

    typedef struct packed {
        logic [10:0]       x;
        logic [10:0]       y;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic [0:0] {StIdle, StPend} swap_st_e;

    // Write-request FIFO; pointers carry one extra wrap bit to tell full from empty.
    wr_req_t         fifo_q [FIFO_DEPTH];
    logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
    logic            fifo_empty, fifo_full;
    logic            push, pop;
    wr_req_t         head;

    // Slot arbitration
    logic            rd_grant, wr_grant, head_in_range;
    logic [LinW-1:0] rd_lin, wr_lin;

    // SRAM access registers
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic              rd_acc_q, blank_q, wr_acc_q;
    logic [DATA_W-1:0] pixel_q, pixel_d;

    // Bank swap
    swap_st_e          swap_st_q;
    logic              disp_bank_q, swap_done_q, vsync_q, vsync_fall;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]) &&
                        (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]);
    assign head       = fifo_q[rd_ptr_q[PtrW-1:0]];
    assign push       = bus.i_wr_valid && !fifo_full;

    assign rd_grant   = bus.i_pix_en && bus.i_vga_active;
    assign wr_grant   = !rd_grant && !fifo_empty;
    assign pop        = wr_grant;

    assign head_in_range = (32'(head.x) < H_ACT) && (32'(head.y) < V_ACT);

    assign rd_lin = LinW'(bus.i_vga_y) * LinW'(H_ACT) + LinW'(bus.i_vga_x);
    assign wr_lin = LinW'(head.y) * LinW'(H_ACT) + LinW'(head.x);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[PtrW-1:0]] <= '{x: bus.i_wr_x, y: bus.i_wr_y, data: bus.i_wr_data};
        end
    end

    // Out-of-range entries still take the slot but leave the strobes idle.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        if (rd_grant) begin
            addr_d = {disp_bank_q, rd_lin};
            oe_n_d = 1'b0;
        end else if (wr_grant && head_in_range) begin
            addr_d  = {~disp_bank_q, wr_lin};
            wdata_d = head.data;
            we_n_d  = 1'b0;
        end
    end

    always_comb begin
        pixel_d = pixel_q;
        if (rd_acc_q) begin
            pixel_d = bus.i_sram_rdata;
        end else if (blank_q) begin
            pixel_d = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            we_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            rd_acc_q <= 1'b0;
            blank_q  <= 1'b0;
            wr_acc_q <= 1'b0;
            pixel_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_n_q   <= we_n_d;
            oe_n_q   <= oe_n_d;
            rd_acc_q <= rd_grant;
            blank_q  <= bus.i_pix_en && !bus.i_vga_active;
            wr_acc_q <= wr_grant;
            pixel_q  <= pixel_d;
        end
    end

    assign vsync_fall = vsync_q && !bus.i_vsync_n;

    // Swap only when nothing queued and no write slot is on the pins, so every pending draw
    // lands in the bank that is about to be shown.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            swap_st_q   <= StIdle;
            disp_bank_q <= 1'b0;
            swap_done_q <= 1'b0;
            vsync_q     <= 1'b1;
        end else begin
            vsync_q     <= bus.i_vsync_n;
            swap_done_q <= 1'b0;
            unique case (swap_st_q)
                StIdle: begin
                    if (bus.i_swap_req) swap_st_q <= StPend;
                end
                StPend: begin
                    if (vsync_fall && fifo_empty && !wr_acc_q) begin
                        disp_bank_q <= ~disp_bank_q;
                        swap_done_q <= 1'b1;
                        swap_st_q   <= StIdle;
                    end
                end
                default: swap_st_q <= StIdle;
            endcase
        end
    end

    assign bus.o_pixel      = pixel_q;
    assign bus.o_wr_ready   = !fifo_full;
    assign bus.o_swap_done  = swap_done_q;
    assign bus.o_disp_bank  = disp_bank_q;
    assign bus.o_sram_addr  = addr_q;
    assign bus.o_sram_wdata = wdata_q;
    assign bus.o_sram_we_n  = we_n_q;
    assign bus.o_sram_oe_n  = oe_n_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: read path, write FIFO, range filtering, bank swap, reset.
module tb_vga_fb_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus ();

    vga_fb_arbiter #(
        .ADDR_W(20), .DATA_W(16), .H_ACT(640), .V_ACT(480), .FIFO_DEPTH(4)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    // Asynchronous SRAM stand-in: data is a fixed scramble of the address while OE is low.
    always_comb begin
        bus.i_sram_rdata = bus.o_sram_oe_n ? 16'hDEAD : (bus.o_sram_addr[15:0] ^ 16'h5A5A);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic v, input logic [10:0] x, input logic [10:0] y,
                          input logic [15:0] d);
        bus.i_wr_valid = v;
        bus.i_wr_x     = x;
        bus.i_wr_y     = y;
        bus.i_wr_data  = d;
    endtask

    task automatic chk_wr(input string tag, input logic [19:0] a, input logic [15:0] d);
        chk({tag, "_we"},   bus.o_sram_we_n, 1'b0);
        chk({tag, "_oe"},   bus.o_sram_oe_n, 1'b1);
        chk({tag, "_addr"}, bus.o_sram_addr, a);
        chk({tag, "_data"}, bus.o_sram_wdata, d);
    endtask

    initial begin
        bus.i_pix_en = 0; bus.i_vga_x = 0; bus.i_vga_y = 0; bus.i_vga_active = 0;
        bus.i_vsync_n = 1; bus.i_swap_req = 0;
        set_wr(0, 0, 0, 0);

        // Reset state
        step(); step();
        chk("rst_pixel", bus.o_pixel, 0);
        chk("rst_addr",  bus.o_sram_addr, 0);
        chk("rst_wdata", bus.o_sram_wdata, 0);
        chk("rst_we",    bus.o_sram_we_n, 1);
        chk("rst_oe",    bus.o_sram_oe_n, 1);
        chk("rst_bank",  bus.o_disp_bank, 0);
        chk("rst_done",  bus.o_swap_done, 0);
        chk("rst_ready", bus.o_wr_ready, 1);
        rst = 0;

        // Display read at (5,2), bank 0: addr 1285, pixel 0x0505^0x5A5A two cycles later
        bus.i_vga_active = 1; bus.i_pix_en = 1; bus.i_vga_x = 5; bus.i_vga_y = 2;
        step();
        chk("rd_addr", bus.o_sram_addr, 20'd1285);
        chk("rd_oe",   bus.o_sram_oe_n, 0);
        chk("rd_we",   bus.o_sram_we_n, 1);
        bus.i_pix_en = 0;
        step();
        chk("rd_pixel", bus.o_pixel, 16'h5F5F);
        chk("rd_idle_oe", bus.o_sram_oe_n, 1);

        // Blanked pixel strobe loads 0
        bus.i_vga_active = 0; bus.i_pix_en = 1;
        step();
        bus.i_pix_en = 0;
        step();
        chk("blank_pixel", bus.o_pixel, 0);

        // Fill the FIFO while every slot is a read, then drain in non-strobe slots
        bus.i_vga_active = 1; bus.i_pix_en = 1; bus.i_vga_x = 0; bus.i_vga_y = 0;
        set_wr(1, 3, 1, 16'hABCD);   step();
        set_wr(1, 10, 0, 16'h1111);  step();
        set_wr(1, 0, 479, 16'h2222); step();
        set_wr(1, 639, 479, 16'h3333); step();
        set_wr(1, 9, 9, 16'h9999);
        chk("full_ready", bus.o_wr_ready, 0);
        set_wr(0, 0, 0, 0);
        bus.i_pix_en = 0; step();
        chk_wr("w0", 20'h80283, 16'hABCD);
        bus.i_pix_en = 1; step();
        chk("w_strobe_oe", bus.o_sram_oe_n, 0);
        chk("w_strobe_we", bus.o_sram_we_n, 1);
        bus.i_pix_en = 0; step();
        chk_wr("w1", 20'h8000A, 16'h1111);
        bus.i_pix_en = 1; step();
        bus.i_pix_en = 0; step();
        chk_wr("w2", 20'hCAD80, 16'h2222);
        bus.i_pix_en = 1; step();
        bus.i_pix_en = 0; step();
        chk_wr("w3", 20'hCAFFF, 16'h3333);
        step();
        chk("drain_we",    bus.o_sram_we_n, 1);
        chk("drain_addr",  bus.o_sram_addr, 20'hCAFFF);
        chk("drain_ready", bus.o_wr_ready, 1);

        // Out-of-range entry consumes a slot without a write
        bus.i_vga_active = 0;
        set_wr(1, 640, 0, 16'hBEEF); step();
        set_wr(1, 1, 1, 16'h4444);   step();
        set_wr(0, 0, 0, 0);
        chk("oor_we", bus.o_sram_we_n, 1);
        step();
        chk_wr("after_oor", 20'h80281, 16'h4444);
        step();

        // Swap after queued writes drain; edge presented only once the pins are idle
        bus.i_swap_req = 1; set_wr(1, 2, 0, 16'h5555); step();
        bus.i_swap_req = 0; set_wr(1, 3, 0, 16'h6666); step();
        set_wr(0, 0, 0, 0); step();
        chk_wr("sw_w1", 20'h80003, 16'h6666);
        step();
        chk("sw_pre_done", bus.o_swap_done, 0);
        bus.i_vsync_n = 0; step();
        chk("sw_done", bus.o_swap_done, 1);
        chk("sw_bank", bus.o_disp_bank, 1);
        bus.i_vsync_n = 1; step();
        chk("sw_done_pulse", bus.o_swap_done, 0);
        set_wr(1, 4, 0, 16'h7777); step();
        set_wr(0, 0, 0, 0); step();
        chk_wr("sw_newbank", 20'h00004, 16'h7777);

        // Swap deferred by a busy FIFO at edge 1, taken at edge 2; repeat request ignored
        bus.i_swap_req = 1; set_wr(1, 5, 0, 16'h0505); step();
        bus.i_swap_req = 0; set_wr(1, 6, 0, 16'h0606); bus.i_vsync_n = 0; step();
        chk("def_done1", bus.o_swap_done, 0);
        chk("def_bank1", bus.o_disp_bank, 1);
        bus.i_vsync_n = 1; set_wr(0, 0, 0, 0); bus.i_swap_req = 1; step();
        bus.i_swap_req = 0;
        chk_wr("def_w", 20'h00006, 16'h0606);
        step();
        bus.i_vsync_n = 0; step();
        chk("def_done2", bus.o_swap_done, 1);
        chk("def_bank2", bus.o_disp_bank, 0);
        bus.i_vsync_n = 1; step();
        chk("def_pulse", bus.o_swap_done, 0);
        bus.i_vsync_n = 0; step();
        chk("def_once_done", bus.o_swap_done, 0);
        chk("def_once_bank", bus.o_disp_bank, 0);
        bus.i_vsync_n = 1;

        // Reset during a write access
        set_wr(1, 7, 0, 16'h8888); step();
        set_wr(1, 8, 0, 16'h9999); step();
        set_wr(0, 0, 0, 0);
        chk_wr("rw_pre", 20'h80007, 16'h8888);
        #1 rst = 1;
        #1;
        chk("rw_we_now", bus.o_sram_we_n, 1);
        chk("rw_ready",  bus.o_wr_ready, 1);
        chk("rw_addr",   bus.o_sram_addr, 0);
        step();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rw_no_write", bus.o_sram_we_n, 1);
        end
        chk("rw_ready_post", bus.o_wr_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
